// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - XLEN_DEF     : default data/address width
//   - SWHB_*       : access-size codes carried on mem_swhb
//   - lsu_state_e  : FSM state encoding (IDLE, REQ, DONE)
//   - ampattern()  : byte-enable pattern for a size code and byte lane
//   - is_aligned() : alignment rule for a size code and byte lane
package dmem_lsu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] SWHB_WORD0 = 2'b00;  // legacy encoding, behaves as word
  localparam logic [1:0] SWHB_WORD  = 2'b01;
  localparam logic [1:0] SWHB_HALF  = 2'b10;
  localparam logic [1:0] SWHB_BYTE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Byte-enable pattern gadget: word 1111, half 0011/1100, byte one-hot.
  function automatic logic [3:0] ampattern(input logic [1:0] swhb,
                                           input logic [1:0] lane);
    case (swhb)
      SWHB_HALF: ampattern = lane[1] ? 4'b1100 : 4'b0011;
      SWHB_BYTE: ampattern = 4'b0001 << lane;
      default:   ampattern = 4'b1111;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] swhb,
                                      input logic [1:0] lane);
    case (swhb)
      SWHB_HALF: is_aligned = ~lane[0];
      SWHB_BYTE: is_aligned = 1'b1;
      default:   is_aligned = (lane == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Signal bundle between the MEM stage / data memory and the load/store unit.
//   MEM side : mem_valid, mem_we, mem_swhb, mem_unsigned, mem_addr, mem_wdata
//              -> stall, ld_valid, ld_data, misalign, bus_err
//   Bus side : bus_req, bus_we, bus_addr, bus_be, bus_wdata
//              <- bus_ack, bus_rdata
//   Debug    : dbg_state (current FSM state)
//
// Handshake semantics: on the MEM side mem_valid is the request valid and
// ~stall is its ready; a request is taken on a rising edge where
// mem_valid=1 and stall=1 while the unit is idle (the stall of an accepted
// access holds the request stable until DONE). On the bus side bus_req is
// the valid, bus_ack the ready; the transfer completes on the edge where
// both are 1, and bus_rdata is only meaningful together with bus_ack.
// Modports: slave = load/store unit, master = pipeline plus data memory.
interface dmem_lsu_if
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            mem_valid;
  logic            mem_we;
  logic [1:0]      mem_swhb;
  logic            mem_unsigned;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            stall;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            misalign;
  logic            bus_err;
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;
  lsu_state_e      dbg_state;

  modport slave (
    input  mem_valid, mem_we, mem_swhb, mem_unsigned, mem_addr, mem_wdata,
    input  bus_ack, bus_rdata,
    output stall, ld_valid, ld_data, misalign, bus_err,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata, dbg_state
  );

  modport master (
    output mem_valid, mem_we, mem_swhb, mem_unsigned, mem_addr, mem_wdata,
    output bus_ack, bus_rdata,
    input  stall, ld_valid, ld_data, misalign, bus_err,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata, dbg_state
  );
endinterface

// File: rtl/lsu_ldext.sv
// Load lane selection and extension (combinational).
//   rdata_i    : raw bus read word
//   swhb_i     : access size code
//   lane_i     : byte address bits [1:0] of the access
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : right-aligned, extended load result
module lsu_ldext
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      swhb_i,
  input  logic [1:0]      lane_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    case (lane_i)
      2'd0:    byte_w = rdata_i[7:0];
      2'd1:    byte_w = rdata_i[15:8];
      2'd2:    byte_w = rdata_i[23:16];
      default: byte_w = rdata_i[31:24];
    endcase
    half_w = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (swhb_i)
      SWHB_BYTE: data_o = {{(XLEN-8){byte_w[7] & ~unsigned_i}}, byte_w};
      SWHB_HALF: data_o = {{(XLEN-16){half_w[15] & ~unsigned_i}}, half_w};
      default:   data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit. Accepts one aligned access from the MEM
// stage, runs a single bus transaction (with a wait timeout), and returns
// the extended load data with a one-cycle ld_valid pulse.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   lsu   : dmem_lsu_if.slave bundle (MEM-side, bus-side and debug signals)
// Parameters: XLEN data/address width, TIMEOUT bus-wait limit (1..255).
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = 255
) (
  input logic      clk,
  input logic      reset,
  dmem_lsu_if.slave lsu
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e      state_q;
  logic [7:0]      cnt_q;
  logic            we_q;
  logic            uns_q;
  logic [1:0]      swhb_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [3:0]      bus_be_q;
  logic            ld_valid_q;
  logic [XLEN-1:0] ld_data_q;
  logic            misalign_q;
  logic            bus_err_q;

  logic            aligned_w;
  logic            accept_w;
  logic [XLEN-1:0] ld_ext_d;

  assign aligned_w = is_aligned(lsu.mem_swhb, lsu.mem_addr[1:0]);
  assign accept_w  = (state_q == ST_IDLE) && lsu.mem_valid && aligned_w;
  // Gated by reset so the pipeline is released the moment reset asserts.
  assign lsu.stall = reset && (accept_w || (state_q == ST_REQ));

  lsu_ldext #(.XLEN(XLEN)) u_ldext (
    .rdata_i    (lsu.bus_rdata),
    .swhb_i     (swhb_q),
    .lane_i     (addr_q[1:0]),
    .unsigned_i (uns_q),
    .data_o     (ld_ext_d)
  );

  always_comb begin
    case (swhb_q)
      SWHB_HALF: lsu.bus_wdata = XLEN'({2{wdata_q[15:0]}});
      SWHB_BYTE: lsu.bus_wdata = XLEN'({4{wdata_q[7:0]}});
      default:   lsu.bus_wdata = wdata_q;
    endcase
  end

  assign lsu.bus_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign lsu.bus_req   = bus_req_q;
  assign lsu.bus_we    = bus_we_q;
  assign lsu.bus_be    = bus_be_q;
  assign lsu.ld_valid  = ld_valid_q;
  assign lsu.ld_data   = ld_data_q;
  assign lsu.misalign  = misalign_q;
  assign lsu.bus_err   = bus_err_q;
  assign lsu.dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      swhb_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_be_q   <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      ld_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lsu.mem_valid) begin
            if (aligned_w) begin
              we_q      <= lsu.mem_we;
              uns_q     <= lsu.mem_unsigned;
              swhb_q    <= lsu.mem_swhb;
              addr_q    <= lsu.mem_addr;
              wdata_q   <= lsu.mem_wdata;
              bus_req_q <= 1'b1;
              bus_we_q  <= lsu.mem_we;
              bus_be_q  <= ampattern(lsu.mem_swhb, lsu.mem_addr[1:0]);
              cnt_q     <= '0;
              state_q   <= ST_REQ;
            end else begin
              misalign_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (lsu.bus_ack) begin
            if (!we_q) begin
              ld_data_q  <= ld_ext_d;
              ld_valid_q <= 1'b1;
            end
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            state_q   <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Timed out: the access completes with zero data.
            ld_data_q  <= '0;
            ld_valid_q <= ~we_q;
            bus_err_q  <= 1'b1;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a default-TIMEOUT instance for the main
// load/store/misalign/reset scenarios and a TIMEOUT=4 instance for the
// bus-timeout scenario.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   stall_cnt;
  logic [31:0] exp_q[$];

  dmem_lsu_if #(.XLEN(32)) m ();
  dmem_lsu_if #(.XLEN(32)) t ();

  dmem_lsu #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (m)
  );

  dmem_lsu #(.XLEN(32), .TIMEOUT(4)) dut_to (
    .clk   (clk),
    .reset (reset),
    .lsu   (t)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every ld_valid pulse of the main instance must match the next queued
  // expected load value.
  always @(negedge clk) begin
    if (reset && m.ld_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL ld_valid_unexpected observed=%h expected=no_pulse", m.ld_data);
      end
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (m.ld_data === e) else begin
          failures++;
          $error("FAIL sb_ld_data observed=%h expected=%h", m.ld_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Load with ack in the first REQ cycle; called at a negedge in IDLE.
  task automatic do_load(input string tag, input logic [1:0] swhb,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    m.mem_valid    = 1'b1;
    m.mem_we       = 1'b0;
    m.mem_swhb     = swhb;
    m.mem_unsigned = uns;
    m.mem_addr     = addr;
    m.mem_wdata    = $urandom;
    #1 chk({tag, "_stall_c1"}, 32'(m.stall), 32'd1);
    tick();
    chk({tag, "_bus_req"}, 32'(m.bus_req), 32'd1);
    chk({tag, "_bus_be"}, 32'(m.bus_be), 32'(exp_be));
    chk({tag, "_bus_addr"}, m.bus_addr, {addr[31:2], 2'b00});
    chk({tag, "_bus_we"}, 32'(m.bus_we), 32'd0);
    m.bus_ack   = 1'b1;
    m.bus_rdata = rdata;
    exp_q.push_back(exp_data);
    tick();
    // DONE: mem_valid is still high here and must be ignored.
    chk({tag, "_ld_valid_c3"}, 32'(m.ld_valid), 32'd1);
    chk({tag, "_ld_data"}, m.ld_data, exp_data);
    chk({tag, "_stall_done"}, 32'(m.stall), 32'd0);
    chk({tag, "_req_done"}, 32'(m.bus_req), 32'd0);
    m.bus_ack   = 1'b0;
    m.mem_valid = 1'b0;
    tick();
    chk({tag, "_ld_valid_off"}, 32'(m.ld_valid), 32'd0);
    chk({tag, "_ld_hold"}, m.ld_data, exp_data);
    chk({tag, "_idle"}, 32'(m.dbg_state), 32'(ST_IDLE));
  endtask

  task automatic do_store(input string tag, input logic [1:0] swhb,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    m.mem_valid    = 1'b1;
    m.mem_we       = 1'b1;
    m.mem_swhb     = swhb;
    m.mem_unsigned = 1'b0;
    m.mem_addr     = addr;
    m.mem_wdata    = wdata;
    tick();
    chk({tag, "_bus_req"}, 32'(m.bus_req), 32'd1);
    chk({tag, "_bus_we"}, 32'(m.bus_we), 32'd1);
    chk({tag, "_bus_be"}, 32'(m.bus_be), 32'(exp_be));
    chk({tag, "_bus_wdata"}, m.bus_wdata, exp_wdata);
    chk({tag, "_bus_addr"}, m.bus_addr, {addr[31:2], 2'b00});
    m.mem_valid = 1'b0;
    m.bus_ack   = 1'b1;
    m.bus_rdata = $urandom;
    tick();
    chk({tag, "_no_ld_valid"}, 32'(m.ld_valid), 32'd0);
    chk({tag, "_we_done"}, 32'(m.bus_we), 32'd0);
    m.bus_ack = 1'b0;
    tick();
  endtask

  task automatic do_misalign(input string tag, input logic [1:0] swhb,
                             input logic [31:0] addr);
    m.mem_valid    = 1'b1;
    m.mem_we       = 1'b0;
    m.mem_swhb     = swhb;
    m.mem_unsigned = 1'b0;
    m.mem_addr     = addr;
    #1 chk({tag, "_stall_c1"}, 32'(m.stall), 32'd0);
    tick();
    chk({tag, "_misalign"}, 32'(m.misalign), 32'd1);
    chk({tag, "_bus_req"}, 32'(m.bus_req), 32'd0);
    chk({tag, "_stall"}, 32'(m.stall), 32'd0);
    chk({tag, "_state"}, 32'(m.dbg_state), 32'(ST_IDLE));
    m.mem_valid = 1'b0;
    tick();
    chk({tag, "_misalign_off"}, 32'(m.misalign), 32'd0);
    chk({tag, "_bus_req_off"}, 32'(m.bus_req), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    {m.mem_valid, m.mem_we, m.mem_unsigned, m.bus_ack} = '0;
    m.mem_swhb = '0; m.mem_addr = '0; m.mem_wdata = '0; m.bus_rdata = '0;
    {t.mem_valid, t.mem_we, t.mem_unsigned, t.bus_ack} = '0;
    t.mem_swhb = '0; t.mem_addr = '0; t.mem_wdata = '0; t.bus_rdata = '0;

    @(negedge clk);
    chk("rst_bus_req", 32'(m.bus_req), 32'd0);
    chk("rst_bus_we", 32'(m.bus_we), 32'd0);
    chk("rst_bus_be", 32'(m.bus_be), 32'd0);
    chk("rst_ld_valid", 32'(m.ld_valid), 32'd0);
    chk("rst_ld_data", m.ld_data, 32'd0);
    chk("rst_misalign", 32'(m.misalign), 32'd0);
    chk("rst_bus_err", 32'(m.bus_err), 32'd0);
    chk("rst_stall", 32'(m.stall), 32'd0);
    chk("rst_state", 32'(m.dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    tick();

    // Loads with ack on the first REQ cycle.
    do_load("lb_lane3", SWHB_BYTE, 1'b0, 32'h8000_0003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu_lane1", SWHB_BYTE, 1'b1, 32'h8000_0001, 32'h1234_F0AB, 4'b0010, 32'h0000_00F0);
    do_load("lh_upper", SWHB_HALF, 1'b0, 32'h8000_0002, 32'h8001_7FFF, 4'b1100, 32'hFFFF_8001);
    do_load("lw_code00", SWHB_WORD0, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb_lane0", SWHB_BYTE, 1'b0, 32'h8000_0008, 32'h0000_007F, 4'b0001, 32'h0000_007F);
    do_load("lb_lane2", SWHB_BYTE, 1'b0, 32'h8000_000A, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);

    // Stores.
    do_store("sh_upper", SWHB_HALF, 32'h8000_0002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_store("sb_lane1", SWHB_BYTE, 32'h8000_0001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
    do_store("sw", SWHB_WORD, 32'h8000_000C, 32'h0123_4567, 4'b1111, 32'h0123_4567);

    // Misaligned accesses.
    do_misalign("mis_lw", SWHB_WORD, 32'h8000_0001);
    do_misalign("mis_lh", SWHB_HALF, 32'h8000_0003);
    do_misalign("mis_code00", SWHB_WORD0, 32'h8000_0002);

    // bus_ack while idle is ignored.
    m.bus_ack = 1'b1;
    m.bus_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("idle_ack_ld_valid", 32'(m.ld_valid), 32'd0);
    chk("idle_ack_state", 32'(m.dbg_state), 32'(ST_IDLE));
    m.bus_ack = 1'b0;

    // lhu with ack in the fifth REQ cycle: stall high for six cycles.
    m.mem_valid    = 1'b1;
    m.mem_we       = 1'b0;
    m.mem_swhb     = SWHB_HALF;
    m.mem_unsigned = 1'b1;
    m.mem_addr     = 32'h8000_0000;
    stall_cnt = 0;
    #1 if (m.stall) stall_cnt++;
    tick();
    for (int k = 2; k <= 6; k++) begin
      if (k == 2) chk("lhu_bus_be", 32'(m.bus_be), 32'(4'b0011));
      if (m.stall) stall_cnt++;
      m.bus_rdata = $urandom;
      if (k == 6) begin
        m.bus_ack   = 1'b1;
        m.bus_rdata = 32'h1234_F00D;
        exp_q.push_back(32'h0000_F00D);
      end
      tick();
    end
    chk("lhu_stall_cycles", 32'(stall_cnt), 32'd6);
    chk("lhu_ld_valid", 32'(m.ld_valid), 32'd1);
    chk("lhu_ld_data", m.ld_data, 32'h0000_F00D);
    chk("lhu_stall_done", 32'(m.stall), 32'd0);
    m.bus_ack   = 1'b0;
    m.mem_valid = 1'b0;
    tick();

    // Timeout instance: first a good load, then a load that never acks.
    t.mem_valid = 1'b1;
    t.mem_we    = 1'b0;
    t.mem_swhb  = SWHB_WORD;
    t.mem_addr  = 32'h8000_0000;
    tick();
    t.mem_valid = 1'b0;
    t.bus_ack   = 1'b1;
    t.bus_rdata = 32'hCAFE_BABE;
    tick();
    chk("to_pre_ld_data", t.ld_data, 32'hCAFE_BABE);
    t.bus_ack = 1'b0;
    tick();
    t.mem_valid = 1'b1;
    t.mem_addr  = 32'h8000_0020;
    tick();
    t.mem_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_req_%0d", k), 32'(t.bus_req), 32'd1);
      chk($sformatf("to_noerr_%0d", k), 32'(t.bus_err), 32'd0);
      tick();
    end
    chk("to_bus_err", 32'(t.bus_err), 32'd1);
    chk("to_ld_data_zero", t.ld_data, 32'd0);
    chk("to_req_drop", 32'(t.bus_req), 32'd0);
    tick();
    chk("to_bus_err_off", 32'(t.bus_err), 32'd0);
    chk("to_idle", 32'(t.dbg_state), 32'(ST_IDLE));

    // Reset in the middle of REQ.
    m.mem_valid    = 1'b1;
    m.mem_we       = 1'b0;
    m.mem_swhb     = SWHB_WORD;
    m.mem_unsigned = 1'b0;
    m.mem_addr     = 32'h8000_0010;
    tick();
    chk("mrst_req_before", 32'(m.bus_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("mrst_bus_req", 32'(m.bus_req), 32'd0);
    chk("mrst_stall", 32'(m.stall), 32'd0);
    chk("mrst_state", 32'(m.dbg_state), 32'(ST_IDLE));
    m.bus_ack   = 1'b1;
    m.bus_rdata = 32'h5555_AAAA;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m.mem_valid = 1'b0;
    m.bus_ack   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mrst_no_ld_valid_%0d", k), 32'(m.ld_valid), 32'd0);
      chk($sformatf("mrst_no_req_%0d", k), 32'(m.bus_req), 32'd0);
    end
    chk("mrst_ld_data_cleared", m.ld_data, 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
